// File: rtl/mag_pkg.sv
// Shared types and constants for the magnitude scan sequencer.
package mag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Read latency of the FFT result RAM and of the magnitude LUT.
    localparam int RAM_RD_LAT = 1;
    localparam int LUT_RD_LAT = 1;
    // Cycles from issuing a bin address to its magnitude arriving.
    localparam int PIPE_LAT   = RAM_RD_LAT + LUT_RD_LAT;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_NBINS  = 64;

endpackage

// File: rtl/mag_scan_sequencer_peak_tracker.sv
// Running-maximum tracker: strict-greater compare, so ties keep the earliest index.
// The look-ahead outputs include the sample presented this cycle.
module peak_tracker
    import mag_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] value,
    input  logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] acc_val,
    output logic [IDX_W-1:0] acc_idx
);

    logic [WIDTH-1:0] max_val_q, max_val_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;

    // Next accumulator value: clear, take a strictly larger sample, or hold.
    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (clear) begin
            max_val_d = '0;
            max_idx_d = '0;
        end else if (valid && (value > max_val_q)) begin
            max_val_d = value;
            max_idx_d = index;
        end else begin
            max_val_d = max_val_q;
            max_idx_d = max_idx_q;
        end
    end

    // Accumulator registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign acc_val = max_val_d;
    assign acc_idx = max_idx_d;

endmodule

// File: rtl/mag_scan_sequencer.sv
// Magnitude scan sequencer: walks every FFT bin, forwards the RAM samples to the
// magnitude LUT, tags the returned magnitudes with their bin and reports the peak.
module mag_scan_sequencer
    import mag_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NBINS     = DEF_NBINS,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int BIN_LOG   = $clog2(NBINS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [BIN_LOG-1:0]   bin_addr,
    output logic                 bin_rd,
    input  logic [DEPTH_LOG-1:0] bin_real,
    input  logic [DEPTH_LOG-1:0] bin_cplx,
    output logic [DEPTH_LOG-1:0] lut_addr_real,
    output logic [DEPTH_LOG-1:0] lut_addr_cplx,
    output logic                 lut_en,
    input  logic [WIDTH-1:0]     mag_in,
    output logic                 mag_valid,
    output logic [BIN_LOG-1:0]   mag_index,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     peak_mag,
    output logic [BIN_LOG-1:0]   peak_index
);

    localparam logic [BIN_LOG-1:0] LAST_BIN = BIN_LOG'(NBINS - 1);

    state_e                             state_q, state_d;
    logic [BIN_LOG-1:0]                 bin_addr_q, bin_addr_d;
    logic                               bin_rd_q, bin_rd_d;
    // Bit 0 = LUT stage (lut_en), top bit = magnitude stage (mag_valid).
    logic [PIPE_LAT-1:0]                vld_q, vld_d;
    logic [PIPE_LAT-1:0][BIN_LOG-1:0]   idx_q, idx_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [WIDTH-1:0]                   peak_mag_q, peak_mag_d;
    logic [BIN_LOG-1:0]                 peak_index_q, peak_index_d;

    logic                               trk_clear_s;
    logic                               kill_s;
    logic                               drain_empty_s;
    logic [WIDTH-1:0]                   acc_val_s;
    logic [BIN_LOG-1:0]                 acc_idx_s;

    peak_tracker #(
        .WIDTH (WIDTH),
        .IDX_W (BIN_LOG)
    ) u_peak_tracker (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (trk_clear_s),
        .valid   (vld_q[PIPE_LAT-1]),
        .value   (mag_in),
        .index   (idx_q[PIPE_LAT-1]),
        .acc_val (acc_val_s),
        .acc_idx (acc_idx_s)
    );

    // Next-state logic for the FSM, address counter, valid/index pipeline and outputs.
    always_comb begin
        state_d       = state_q;
        bin_addr_d    = bin_addr_q;
        bin_rd_d      = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        peak_mag_d    = peak_mag_q;
        peak_index_d  = peak_index_q;
        trk_clear_s   = 1'b0;
        kill_s        = abort && ((state_q == ST_SCAN) || (state_q == ST_DRAIN));
        // Nothing left in the pipeline ahead of the magnitude stage.
        drain_empty_s = (vld_q[PIPE_LAT-2:0] == '0);

        if (kill_s) begin
            vld_d = '0;
            idx_d = '0;
        end else begin
            vld_d = {vld_q[PIPE_LAT-2:0], bin_rd_q};
            idx_d = {idx_q[PIPE_LAT-2:0], bin_addr_q};
        end

        case (state_q)
            ST_IDLE: begin
                // abort outranks start while idle
                if (!abort && start) begin
                    state_d     = ST_SCAN;
                    bin_rd_d    = 1'b1;
                    bin_addr_d  = '0;
                    busy_d      = 1'b1;
                    trk_clear_s = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    bin_addr_d  = '0;
                    busy_d      = 1'b0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    bin_addr_d = '0;
                    busy_d     = 1'b0;
                end else if (bin_addr_q == LAST_BIN) begin
                    state_d    = ST_DRAIN;
                    bin_addr_d = '0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = ST_SCAN;
                    bin_rd_d   = 1'b1;
                    bin_addr_d = bin_addr_q + BIN_LOG'(1);
                    busy_d     = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (drain_empty_s) begin
                    // Last magnitude is on mag_in now; the look-ahead value includes it.
                    state_d      = ST_DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    peak_mag_d   = acc_val_s;
                    peak_index_d = acc_idx_s;
                end else begin
                    state_d = ST_DRAIN;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                bin_addr_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bin_addr_q   <= '0;
            bin_rd_q     <= 1'b0;
            vld_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            peak_mag_q   <= '0;
            peak_index_q <= '0;
        end else begin
            state_q      <= state_d;
            bin_addr_q   <= bin_addr_d;
            bin_rd_q     <= bin_rd_d;
            vld_q        <= vld_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            peak_mag_q   <= peak_mag_d;
            peak_index_q <= peak_index_d;
        end
    end

    assign bin_addr      = bin_addr_q;
    assign bin_rd        = bin_rd_q;
    assign lut_en        = vld_q[0];
    // RAM data goes straight to the LUT; forced to zero when no sample is in flight.
    assign lut_addr_real = vld_q[0] ? bin_real : '0;
    assign lut_addr_cplx = vld_q[0] ? bin_cplx : '0;
    assign mag_valid     = vld_q[PIPE_LAT-1];
    assign mag_index     = idx_q[PIPE_LAT-1];
    assign busy          = busy_q;
    assign done          = done_q;
    assign peak_mag      = peak_mag_q;
    assign peak_index    = peak_index_q;

endmodule

// File: tb/tb_mag_scan_sequencer.sv
// Directed bench for mag_scan_sequencer with behavioural FFT RAM and magnitude LUT.
module tb_mag_scan_sequencer;

    localparam int NBINS = 64;
    localparam int NONE  = -10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  bin_addr;
    logic        bin_rd;
    logic [7:0]  bin_real = 8'd0;
    logic [7:0]  bin_cplx = 8'd0;
    logic [7:0]  lut_addr_real, lut_addr_cplx;
    logic        lut_en;
    logic [15:0] mag_in = 16'd0;
    logic        mag_valid;
    logic [5:0]  mag_index;
    logic        busy, done;
    logic [15:0] peak_mag;
    logic [5:0]  peak_index;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_real [NBINS];
    logic [7:0] mem_cplx [NBINS];
    bit         sq_mode = 1'b0;

    // results of run_scan
    int r_done_c, r_rd_first, r_rd_cnt, r_lut_first, r_lut_cnt, r_mv_first, r_mv_cnt;
    bit r_addr_ok, r_idx_ok, r_peak_held, r_quiet, r_done_next;

    mag_scan_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .bin_addr(bin_addr), .bin_rd(bin_rd), .bin_real(bin_real), .bin_cplx(bin_cplx),
        .lut_addr_real(lut_addr_real), .lut_addr_cplx(lut_addr_cplx), .lut_en(lut_en),
        .mag_in(mag_in), .mag_valid(mag_valid), .mag_index(mag_index),
        .busy(busy), .done(done), .peak_mag(peak_mag), .peak_index(peak_index)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] lut_f(input logic [7:0] x);
        if (sq_mode) lut_f = 16'(x) * 16'(x);
        else         lut_f = {8'd0, x};
    endfunction

    // FFT result RAM, 1-cycle registered read
    always @(posedge clock) begin
        if (bin_rd) begin
            bin_real <= mem_real[bin_addr];
            bin_cplx <= mem_cplx[bin_addr];
        end
    end

    // magnitude LUT, 1-cycle registered read, sum of both lookups
    always @(posedge clock) begin
        if (lut_en) mag_in <= lut_f(lut_addr_real) + lut_f(lut_addr_cplx);
    end

    task automatic load_ramp();
        sq_mode = 1'b0;
        for (int k = 0; k < NBINS; k++) begin mem_real[k] = 8'(k); mem_cplx[k] = 8'd0; end
    endtask

    task automatic load_spike();
        sq_mode = 1'b1;
        for (int k = 0; k < NBINS; k++) begin mem_real[k] = 8'd0; mem_cplx[k] = 8'd0; end
        mem_real[17] = 8'h40; mem_cplx[17] = 8'h10;
    endtask

    task automatic load_tie();
        sq_mode = 1'b1;
        for (int k = 0; k < NBINS; k++) begin mem_real[k] = 8'(k % 16); mem_cplx[k] = 8'd0; end
        mem_real[5]  = 8'd16; mem_cplx[5]  = 8'd16;
        mem_real[40] = 8'd16; mem_cplx[40] = 8'd16;
    endtask

    // Pulse start, then observe cycles 1..max_c after the start edge (no checking here).
    task automatic run_scan(input int start_c, input int abort_c, input int reset_c, input int max_c);
        logic [15:0] p0;
        logic [5:0]  i0;
        r_done_c = -1; r_rd_first = -1; r_lut_first = -1; r_mv_first = -1;
        r_rd_cnt = 0; r_lut_cnt = 0; r_mv_cnt = 0;
        r_addr_ok = 1'b1; r_idx_ok = 1'b1; r_peak_held = 1'b1; r_quiet = 1'b0; r_done_next = 1'b0;
        p0 = peak_mag; i0 = peak_index;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            if (bin_rd) begin
                if (r_rd_cnt == 0) r_rd_first = c;
                if (int'(bin_addr) != r_rd_cnt) r_addr_ok = 1'b0;
                r_rd_cnt++;
            end
            if (lut_en) begin
                if (r_lut_cnt == 0) r_lut_first = c;
                r_lut_cnt++;
            end
            if (mag_valid) begin
                if (r_mv_cnt == 0) r_mv_first = c;
                if (int'(mag_index) != r_mv_cnt) r_idx_ok = 1'b0;
                r_mv_cnt++;
            end
            if (r_done_c > 0 && c == r_done_c + 1) r_done_next = done;
            if (done && r_done_c < 0) r_done_c = c;
            if (r_done_c < 0 && (peak_mag != p0 || peak_index != i0)) r_peak_held = 1'b0;
            if (c == abort_c + 1)
                r_quiet = ({busy, bin_rd, lut_en, mag_valid, done} == 5'd0);
            if (c == reset_c + 1)
                r_quiet = ({bin_addr, bin_rd, lut_addr_real, lut_addr_cplx, lut_en, mag_valid,
                            mag_index, busy, done, peak_mag, peak_index} == 63'd0);
            start   = (c == start_c);
            abort   = (c == abort_c);
            reset_n = (c != reset_c);
            @(negedge clock);
        end
        start = 1'b0; abort = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++; if (bin_addr !== 6'd0) begin n_fail++; $display("FAIL reset_bin_addr: got %0d want 0", bin_addr); end
        n_tests++; if (bin_rd !== 1'b0) begin n_fail++; $display("FAIL reset_bin_rd: got %b want 0", bin_rd); end
        n_tests++; if (lut_en !== 1'b0) begin n_fail++; $display("FAIL reset_lut_en: got %b want 0", lut_en); end
        n_tests++; if ({lut_addr_real, lut_addr_cplx} !== 16'd0) begin n_fail++; $display("FAIL reset_lut_addr: got %h want 0", {lut_addr_real, lut_addr_cplx}); end
        n_tests++; if ({mag_valid, mag_index} !== 7'd0) begin n_fail++; $display("FAIL reset_mag: got %h want 0", {mag_valid, mag_index}); end
        n_tests++; if ({busy, done} !== 2'd0) begin n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        n_tests++; if ({peak_mag, peak_index} !== 22'd0) begin n_fail++; $display("FAIL reset_peak: got %h want 0", {peak_mag, peak_index}); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ramp();
        load_ramp();
        run_scan(NONE, NONE, NONE, NBINS + 4);
        n_tests++; if (r_rd_first != 1 || r_rd_cnt != 64) begin n_fail++; $display("FAIL ramp_bin_rd: first %0d cnt %0d want 1/64", r_rd_first, r_rd_cnt); end
        n_tests++; if (r_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ramp_bin_addr: order ok=%b want 1", r_addr_ok); end
        n_tests++; if (r_lut_first != 2 || r_lut_cnt != 64) begin n_fail++; $display("FAIL ramp_lut_en: first %0d cnt %0d want 2/64", r_lut_first, r_lut_cnt); end
        n_tests++; if (r_mv_first != 3 || r_mv_cnt != 64) begin n_fail++; $display("FAIL ramp_mag_valid: first %0d cnt %0d want 3/64", r_mv_first, r_mv_cnt); end
        n_tests++; if (r_idx_ok !== 1'b1) begin n_fail++; $display("FAIL ramp_mag_index: order ok=%b want 1", r_idx_ok); end
        n_tests++; if (r_done_c != 67) begin n_fail++; $display("FAIL ramp_done_cycle: got %0d want 67", r_done_c); end
        n_tests++; if (r_done_next !== 1'b0) begin n_fail++; $display("FAIL ramp_done_pulse: next cycle done=%b want 0", r_done_next); end
        n_tests++; if (peak_mag !== 16'd63 || peak_index !== 6'd63) begin n_fail++; $display("FAIL ramp_peak: got %0d@%0d want 63@63", peak_mag, peak_index); end
    endtask

    task automatic test_spike();
        load_spike();
        run_scan(NONE, NONE, NONE, NBINS + 4);
        n_tests++; if (r_peak_held !== 1'b1) begin n_fail++; $display("FAIL spike_peak_hold: held=%b want 1", r_peak_held); end
        n_tests++; if (r_done_c != 67) begin n_fail++; $display("FAIL spike_done_cycle: got %0d want 67", r_done_c); end
        n_tests++; if (peak_mag !== 16'h1100 || peak_index !== 6'd17) begin n_fail++; $display("FAIL spike_peak: got %h@%0d want 1100@17", peak_mag, peak_index); end
    endtask

    task automatic test_tie();
        load_tie();
        run_scan(NONE, NONE, NONE, NBINS + 4);
        n_tests++; if (peak_mag !== 16'h0200 || peak_index !== 6'd5) begin n_fail++; $display("FAIL tie_peak: got %h@%0d want 0200@5", peak_mag, peak_index); end
    endtask

    task automatic test_start_while_busy();
        load_ramp();
        run_scan(10, NONE, NONE, NBINS + 4);
        n_tests++; if (r_addr_ok !== 1'b1 || r_rd_cnt != 64) begin n_fail++; $display("FAIL busy_start_addr: ok=%b cnt=%0d want 1/64", r_addr_ok, r_rd_cnt); end
        n_tests++; if (r_done_c != 67 || r_done_next !== 1'b0) begin n_fail++; $display("FAIL busy_start_done: cycle %0d next %b want 67/0", r_done_c, r_done_next); end
        n_tests++; if (peak_mag !== 16'd63 || peak_index !== 6'd63) begin n_fail++; $display("FAIL busy_start_peak: got %0d@%0d want 63@63", peak_mag, peak_index); end
    endtask

    task automatic test_abort();
        load_spike();
        run_scan(NONE, 20, NONE, NBINS + 12);
        n_tests++; if (r_quiet !== 1'b1) begin n_fail++; $display("FAIL abort_idle: quiet=%b want 1", r_quiet); end
        n_tests++; if (r_done_c != -1) begin n_fail++; $display("FAIL abort_no_done: done at %0d want none", r_done_c); end
        n_tests++; if (peak_mag !== 16'd63 || peak_index !== 6'd63) begin n_fail++; $display("FAIL abort_peak: got %0d@%0d want 63@63", peak_mag, peak_index); end
    endtask

    task automatic test_reset_mid_scan();
        load_ramp();
        run_scan(NONE, NONE, 30, 40);
        n_tests++; if (r_quiet !== 1'b1) begin n_fail++; $display("FAIL midreset_zero: all_zero=%b want 1", r_quiet); end
        load_spike();
        run_scan(NONE, NONE, NONE, NBINS + 4);
        n_tests++; if (r_rd_first != 1 || r_addr_ok !== 1'b1) begin n_fail++; $display("FAIL midreset_restart: first %0d ok %b want 1/1", r_rd_first, r_addr_ok); end
        n_tests++; if (peak_mag !== 16'h1100 || peak_index !== 6'd17) begin n_fail++; $display("FAIL midreset_peak: got %h@%0d want 1100@17", peak_mag, peak_index); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1, rd2 = -1;
        logic [15:0] p1 = 16'd0, p2 = 16'd0;
        logic [5:0]  i1 = 6'd0, i2 = 6'd0;
        bit prev_rd = 1'b0;
        int rises = 0;
        load_ramp();
        start = 1'b1;
        @(negedge clock);
        for (int c = 1; c <= 140; c++) begin
            if (bin_rd && !prev_rd) begin
                rises++;
                if (rises == 2) rd2 = (bin_addr == 6'd0) ? c : -2;
            end
            prev_rd = bin_rd;
            if (done) begin
                if (d1 < 0) begin d1 = c; p1 = peak_mag; i1 = peak_index; end
                else if (d2 < 0) begin d2 = c; p2 = peak_mag; i2 = peak_index; end
            end
            if (c == 67) begin
                for (int k = 0; k < NBINS; k++) begin mem_real[k] = 8'd0; mem_cplx[k] = 8'd0; end
                mem_real[9] = 8'd20;
            end
            @(negedge clock);
        end
        start = 1'b0;
        n_tests++; if (d1 != 67 || d2 != 135) begin n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d want 67,135", d1, d2); end
        n_tests++; if (rd2 != 69) begin n_fail++; $display("FAIL b2b_restart: got %0d want 69", rd2); end
        n_tests++; if (p1 !== 16'd63 || i1 !== 6'd63) begin n_fail++; $display("FAIL b2b_peak1: got %0d@%0d want 63@63", p1, i1); end
        n_tests++; if (p2 !== 16'd20 || i2 !== 6'd9) begin n_fail++; $display("FAIL b2b_peak2: got %0d@%0d want 20@9", p2, i2); end
        repeat (80) @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_ramp();
        test_spike();
        test_tie();
        test_start_while_busy();
        test_abort();
        test_reset_mid_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
